// File: rtl/lsu_mem_port.sv
// lsu_mem_port: big-endian load/store unit memory port with read-modify-write for sub-word stores
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses with err=1
module lsu_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] data_addr,
    output logic        data_wr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, DONE} state_t;
    state_t state, state_next;
    logic [31:0] addr_q, wdata_q, merge_q, last_addr, load_val, merge_val;
    logic [1:0]  size_q;
    logic        we_q, sign_ext_q, misaligned;
`ifdef LSU_ALIGN_CHECK_EN
    logic        err_q;
    assign misaligned = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    assign err = err_q;
    // error flag is decided at acceptance and presented with the done pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else if (state == IDLE && req) err_q <= misaligned;
`else
    assign misaligned = 1'b0;
    assign err = 1'b0;
`endif
    assign ready = state == IDLE;
    assign done = state == DONE;
    assign data_wr = state == WRITE && we_q;
    assign data_in = data_wr ? (size_q[1] ? wdata_q : merge_q) : '0;
    assign data_addr = (state == LOAD || state == RMW_READ || state == WRITE) ? addr_q : last_addr;
    assign load_val = size_q == 2'b00 ? {{24{sign_ext_q & data_out[31]}}, data_out[31:24]} :
                      size_q == 2'b01 ? {{16{sign_ext_q & data_out[31]}}, data_out[31:16]} : data_out;
    assign merge_val = size_q == 2'b00 ? {wdata_q[7:0], data_out[23:0]} : {wdata_q[15:0], data_out[15:0]};
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;
    // next-state: dispatch on request type, then walk the access sequence back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req) state_next = misaligned ? DONE : !we ? LOAD : size[1] ? WRITE : RMW_READ;
            LOAD:     state_next = DONE;
            RMW_READ: state_next = WRITE;
            WRITE:    state_next = DONE;
            default:  state_next = IDLE;
        endcase
    end
    // latch request fields at acceptance
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
        end else if (state == IDLE && req) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            size_q     <= size;
            we_q       <= we;
            sign_ext_q <= sign_ext;
        end
    // datapath: load result, merge word for sub-word stores, and held memory address
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rdata     <= '0;
            merge_q   <= '0;
            last_addr <= '0;
        end else begin
            last_addr <= data_addr;
            if (state == LOAD && !we_q) rdata <= load_val;
            if (state == RMW_READ) merge_q <= merge_val;
        end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: scoreboard bench with a byte-array reference model for lsu_mem_port
module tb_lsu_mem_port;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    typedef struct {logic [31:0] rd; logic er; int cyc;} exp_t;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0, preload = 1'b1;
    logic [1:0] size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic ready, done, err, data_wr;
    logic [31:0] rdata, data_addr, data_in, data_out;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] a0;
    logic [31:0] last_rd = '0;
    logic [63:0] pre = 64'hDEADBEEF01020304;
    logic [63:0] w;
    exp_t e;
    exp_t sq[$];
    logic [63:0] wq[$];
    int cyc = 0, checks = 0, passed = 0;

    lsu_mem_port dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .err(err),
        .data_addr(data_addr), .data_wr(data_wr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a0 = data_addr[7:0];
    assign data_out = {mem[a0], mem[a0 + 8'd1], mem[a0 + 8'd2], mem[a0 + 8'd3]};
    always @(posedge clk)
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (data_wr) begin
            mem[a0]        <= data_in[31:24];
            mem[a0 + 8'd1] <= data_in[23:16];
            mem[a0 + 8'd2] <= data_in[15:8];
            mem[a0 + 8'd3] <= data_in[7:0];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[8'(a)], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)], ref_mem[8'(a + 3)]};
    endfunction

    // expected behaviour from the access rules: acc is the cycle count at the accepting edge
    task automatic model(input logic wr, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] wd, input int acc);
        int n;
        logic [31:0] v;
        bit mis;
        n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        mis = ALIGN && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
        if (mis) sq.push_back('{last_rd, 1'b1, acc});
        else if (!wr) begin
            v = ref_word(a) >> (32 - 8 * n);
            if (se && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
            last_rd = v;
            sq.push_back('{last_rd, 1'b0, acc + 1});
        end else begin
            for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = 8'(wd >> (8 * (n - 1 - i)));
            wq.push_back({a, ref_word(a)});
            sq.push_back('{last_rd, 1'b0, acc + (n == 4 ? 1 : 2)});
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] wd);
        int k;
        k = 0;
        while (!ready && k < 20) begin @(posedge clk); #1; k++; end
        if (!ready) chk("ready timeout", {31'b0, ready}, 32'd1);
        req = 1'b1; we = wr; size = sz; sign_ext = se; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        model(wr, sz, se, a, wd, cyc);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sq.size() != 0 || !ready) && k < 50) begin @(posedge clk); #1; k++; end
        if (sq.size() != 0) chk("drain timeout", sq.size(), 32'd0);
    endtask

    // monitor: compare every completion and every memory write against the scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (done) begin
                if (sq.size() == 0) chk("unexpected done", 32'd1, 32'd0);
                else begin
                    e = sq.pop_front();
                    chk("rdata", rdata, e.rd);
                    chk("err", {31'b0, err}, {31'b0, e.er});
                    chk("done cycle", cyc, e.cyc);
                end
            end
            if (data_wr) begin
                if (wq.size() == 0) chk("unexpected write", 32'd1, 32'd0);
                else begin
                    w = wq.pop_front();
                    chk("write addr", data_addr, w[63:32]);
                    chk("write data", data_in, w[31:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) ref_mem[16 + i] = pre[63 - 8 * i -: 8];
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'b0, ready}, 32'd1);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
        chk("reset data_wr", {31'b0, data_wr}, 32'd0);
        chk("reset data_addr", data_addr, 32'd0);
        chk("reset data_in", data_in, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        preload = 1'b0;
        rst = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drain();
        chk("load word 0x10", rdata, 32'hDEADBEEF);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0); drain();
        chk("load byte sext", rdata, 32'hFFFFFFAD);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0); drain();
        chk("load byte zext", rdata, 32'h000000AD);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h77;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort ready", {31'b0, ready}, 32'd1);
        chk("abort data_wr", {31'b0, data_wr}, 32'd0);
        chk("abort rdata", rdata, 32'd0);
        last_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drain();
        chk("abort memory", rdata, 32'hDEADBEEF);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
        @(posedge clk); #1;
        model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc);
        addr = 32'h14;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        model(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, cyc);
        drain();
        chk("back-to-back second", rdata, 32'h01020304);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h55); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drain();
        chk("store byte result", rdata, 32'hDEAD55EF);
        issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drain();
        chk("store half result", rdata, ALIGN ? 32'hDEAD55EF : 32'hDE1234EF);
        for (int i = 0; i < 300; i++)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom);
        drain();
        chk("writes outstanding", wq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have core-side inputs: req  in  1  request, sampled only when ready=1; we  in  1  1=store, 0=load; size  in  2  00 byte, 01 half, 10/11 word; sign_ext  in  1  sign-extend sub-word loads; addr  in  32  byte address; wdata  in  32  store data, right-justified.
REQ-003 SHALL have core-side outputs: ready  out  1  idle, can accept; done  out  1  one-cycle completion pulse; rdata  out  32  load result; err  out  1  misaligned flag, valid with done.
REQ-004 SHALL have memory-side ports: data_addr  out  32  memory byte address; data_wr  out  1  write enable; data_in  out  32  write word; data_out  in  32  combinational read word.
REQ-005 Memory model: big-endian; data_out = bytes {A, A+1, A+2, A+3} for data_addr=A, with byte A in [31:24]; a write with data_wr=1 stores all 4 bytes at the next rising edge.

Function
REQ-006 FSM states: IDLE, LOAD, RMW_READ, WRITE, DONE; ready=1 only in IDLE.
REQ-007 IDLE with req=1: latch addr, size, we, sign_ext, wdata; go to LOAD (we=0), WRITE (we=1 and word), RMW_READ (we=1 and byte/half), or DONE with err (misaligned, see REQ-016).
REQ-008 LOAD: data_addr=addr_q, data_wr=0; at cycle end register rdata; go to DONE.
REQ-009 Load extraction: byte = data_out[31:24]; half = data_out[31:16]; word = data_out; sub-word zero-extended if sign_ext=0, sign-extended from bit 7/15 if sign_ext=1.
REQ-010 RMW_READ: data_addr=addr_q, data_wr=0; register merge word = data_out with [31:24] (byte) or [31:16] (half) replaced by wdata[7:0] or wdata[15:0]; go to WRITE.
REQ-011 WRITE: data_addr=addr_q, data_wr=1 for exactly one cycle, data_in = wdata_q (word) or merge word (sub-word); go to DONE.
REQ-012 DONE: done=1 for one cycle, then IDLE; req during DONE is ignored.
REQ-013 Latency from accepting edge: done in 2nd following cycle for load or word store, 3rd for sub-word store, 1st for error.
REQ-014 rdata updates only on completing loads; it holds its value through stores and errors until the next load completes. data_wr=0 in every state except WRITE. Outside LOAD, RMW_READ and WRITE, data_addr holds its last value.
REQ-015 err=0 on every non-error completion. With req held high, back-to-back requests are accepted on the first IDLE cycle after DONE.

Configuration
REQ-016 Macro LSU_ALIGN_CHECK_EN. When defined: a half at an odd addr, or a word with addr[1:0]!=0, goes IDLE->DONE with err=1, data_wr never asserted, rdata unchanged. When undefined: no check, err tied 0, unaligned accesses execute per REQ-008..011.

Reset
REQ-017 rst=1 SHALL immediately force IDLE, ready=1, done=0, err=0, data_wr=0, data_addr=0, data_in=0, rdata=0, all latched request fields 0.
REQ-018 Reset during any operation SHALL abort it; the memory is not written if rst is asserted before the WRITE-cycle clock edge.

Verification
Preload bytes 0x10..0x17 = DE AD BE EF 01 02 03 04.
REQ-019 Load word 0x10 -> rdata=0xDEADBEEF, done in 2nd cycle after accept, err=0.
REQ-020 Load byte 0x11: sign_ext=1 -> 0xFFFFFFAD; sign_ext=0 -> 0x000000AD.
REQ-021 Store byte wdata=0x55 at 0x12 -> single data_wr cycle with data_addr=0x12, data_in=0x55EF0102; then load word 0x10 -> 0xDEAD55EF; done in 3rd cycle.
REQ-022 Store half 0x1234 at 0x11: with LSU_ALIGN_CHECK_EN -> err=1 in 1st cycle, no data_wr, memory unchanged; without it -> load word 0x10 = 0xDE1234EF.
REQ-023 rst pulsed during RMW_READ of a byte store at 0x10 -> data_wr never asserted, ready=1 immediately, word 0x10 still 0xDEADBEEF.
REQ-024 req held high for load 0x10 then load 0x14 -> two done pulses 3 cycles apart, rdata 0xDEADBEEF then 0x01020304.
